// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory from address 0.
// Holds the pipeline in reset until the halt word is stored; stops with overflow if memory fills first.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              inicio,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              pipe_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {COLLECT, WRITE, DONE, ERROR} state_t;
  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  assign rx_ready = inicio && r_state == COLLECT;
  always_ff @(posedge clk) begin
    if (!inicio) begin
      r_state    <= COLLECT;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      pipe_hold  <= 1'b1;
    end else begin
      unique case (r_state)
        COLLECT: if (rx_valid) begin
          r_shift    <= {r_shift[15:0], rx_data};
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            mem_wdata <= {r_shift, rx_data};
            mem_we    <= 1'b1;
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          word_count <= word_count + 1'b1;
          if (mem_wdata == HALT_WORD) begin
            r_state   <= DONE;
            done      <= 1'b1;
            pipe_hold <= 1'b0;
          end else if (mem_addr == '1) begin
            r_state  <= ERROR;
            overflow <= 1'b1;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            r_state  <= COLLECT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives one stimulus stream into a 256-word and a 4-word loader and checks both every cycle
// against a word-level model of the loading rules.
module tb_imem_loader;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  logic       clk = 1'b0;
  logic       inicio = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic        rdy0, we0, hold0, dn0, ov0, rdy1, we1, hold1, dn1, ov1;
  logic [7:0]  ad0;
  logic [1:0]  ad1;
  logic [31:0] wd0, wd1;
  logic [8:0]  wc0;
  logic [2:0]  wc1;
  int n_checks = 0;
  int n_fail = 0;
  int          depth[2] = '{256, 4};
  int          nb[2], cnt[2], st[2];
  bit          pend[2];
  logic [31:0] acc[2], wexp[2];
  always #5 clk = ~clk;
  imem_loader u_big (
    .clk(clk), .inicio(inicio), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy0),
    .mem_we(we0), .mem_addr(ad0), .mem_wdata(wd0), .pipe_hold(hold0), .done(dn0),
    .overflow(ov0), .word_count(wc0)
  );
  imem_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .inicio(inicio), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy1),
    .mem_we(we1), .mem_addr(ad1), .mem_wdata(wd1), .pipe_hold(hold1), .done(dn1),
    .overflow(ov1), .word_count(wc1)
  );
  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask
  function automatic bit exp_ready(input int k);
    return inicio && st[k] == 0 && !pend[k];
  endfunction
  task automatic model_edge(input logic v, input logic [7:0] d, input logic rn);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        nb[k] = 0; cnt[k] = 0; st[k] = 0; pend[k] = 0; acc[k] = '0; wexp[k] = '0;
      end else if (pend[k]) begin
        pend[k] = 0;
        cnt[k]++;
        if (wexp[k] == HALT) st[k] = 1;
        else if (cnt[k] == depth[k]) st[k] = 2;
      end else if (st[k] == 0 && v) begin
        acc[k] = {acc[k][23:0], d};
        nb[k]++;
        if (nb[k] == 4) begin
          nb[k] = 0; pend[k] = 1; wexp[k] = acc[k];
        end
      end
    end
  endtask
  task automatic check_outs(input int k, input logic we, input logic [7:0] ad, input logic [31:0] wd,
                            input logic hold, input logic dn, input logic ov, input logic [8:0] wc);
    chk("mem_we", k, 64'(we), 64'(pend[k]));
    chk("mem_addr", k, 64'(ad), 64'(st[k] != 0 ? cnt[k] - 1 : cnt[k]));
    chk("mem_wdata", k, 64'(wd), 64'(wexp[k]));
    chk("done", k, 64'(dn), 64'(st[k] == 1));
    chk("overflow", k, 64'(ov), 64'(st[k] == 2));
    chk("pipe_hold", k, 64'(hold), 64'(st[k] != 1));
    chk("word_count", k, 64'(wc), 64'(cnt[k]));
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic rn);
    @(negedge clk);
    inicio = rn; rx_valid = v; rx_data = d;
    #1;
    chk("rx_ready", 0, 64'(rdy0), 64'(exp_ready(0)));
    chk("rx_ready", 1, 64'(rdy1), 64'(exp_ready(1)));
    @(posedge clk);
    model_edge(v, d, rn);
    #1;
    check_outs(0, we0, ad0, wd0, hold0, dn0, ov0, wc0);
    check_outs(1, we1, {6'b0, ad1}, wd1, hold1, dn1, ov1, {6'b0, wc1});
  endtask
  task automatic send(input logic [7:0] d);
    bit ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      ok = exp_ready(0);
      cyc(1'b1, d, 1'b1);
    end
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
  endtask
  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
  endtask
  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    return (w == HALT) ? 32'h0 : w;
  endfunction
  initial begin
    logic [31:0] w;
    model_edge(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    do_reset();
    send_word(32'h00112233);
    send_word(HALT);
    repeat (2) cyc(1'b0, 8'h00, 1'b1);
    do_reset();
    w = 32'hDEADBEEF;
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b0, 8'h55, 1'b1);
      send(w[8*i +: 8]);
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    do_reset();
    repeat (4) send_word(rand_word());
    repeat (6) cyc(1'b1, 8'($urandom), 1'b1);
    do_reset();
    repeat (3) send_word(rand_word());
    send_word(HALT);
    repeat (2) cyc(1'b0, 8'h00, 1'b1);
    do_reset();
    send(8'hAA); send(8'hBB);
    cyc(1'b1, 8'hCC, 1'b0);
    send_word(32'h12345678);
    send_word(HALT);
    repeat (8) cyc(1'b1, 8'($urandom), 1'b1);
    do_reset();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    cyc(1'b1, 8'h09, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 2500; i++) begin
      logic rn = !(($urandom % 150) == 0);
      logic v = ($urandom % 3) != 0;
      logic [7:0] d = ($urandom % 2) ? 8'hFF : 8'($urandom);
      cyc(v, d, rn);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
